arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 5, meaning data bits per channel; legal range 1..64.
REQ-002 The block SHALL expose parameter N, default 4, meaning input channel count; legal range 2..16.
REQ-003 The block SHALL expose parameter MODE, default 0, meaning channel choice: 0 = sel-driven, 1 = round-robin arbitration.
REQ-004 The block SHALL derive SW = max(1, $clog2(N)) as the width of sel and grant.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  N  per-channel request; bit i high means channel i offers data.
REQ-009 in_ready  output  N  per-channel accept; combinational; at most one bit high per cycle.
REQ-010 sel  input  SW  channel index used when MODE=0; ignored when MODE=1.
REQ-011 flush  input  1  synchronous discard of the output stage.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data holds a transfer not yet taken.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 grant  output  SW  registered index of the channel whose data is in out_data.

Function
REQ-016 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high at the rising clk edge.
REQ-017 The output stage SHALL be able to load when load_en = !out_valid || out_ready, and flush is low.
REQ-018 in_ready SHALL be all zeros when load_en is low, when flush is high, or while rst_n is low.
REQ-019 In MODE=0, in_ready[sel] SHALL equal load_en && !flush, and all other bits SHALL be 0.
REQ-020 In MODE=0, a sel value >= N SHALL select no channel: in_ready all zeros, no capture.
REQ-021 In MODE=1, the winner SHALL be the first channel with in_valid high, searching upward from pointer ptr and wrapping from N-1 to 0.
REQ-022 In MODE=1, in_ready[winner] SHALL equal load_en && !flush, and all other bits SHALL be 0; with no in_valid bit high, in_ready SHALL be all zeros.
REQ-023 In MODE=1, after a transfer from channel w, ptr SHALL become (w+1) mod N; otherwise ptr SHALL hold.
REQ-024 On a transfer, out_data SHALL capture the winning channel's data, grant SHALL capture its index, and out_valid SHALL be 1 the next cycle; latency is exactly 1 cycle.
REQ-025 If out_valid && out_ready and no new transfer occurs, out_valid SHALL clear next cycle; out_data and grant SHALL hold their values.
REQ-026 While out_valid && !out_ready, out_data, grant and out_valid SHALL stay stable.
REQ-027 Simultaneous output drain and new transfer SHALL replace the held word, with no bubble, for full throughput of one word per cycle.
REQ-028 flush high SHALL clear out_valid next cycle, with no capture that cycle; out_data, grant and ptr SHALL hold.
REQ-029 A changing sel or in_valid without a transfer SHALL NOT alter any registered state.

Reset
REQ-030 Asserting rst_n low SHALL immediately set out_valid=0, out_data=0, grant=0 and ptr=0, independent of clk.
REQ-031 Reset mid-transfer SHALL discard the held word; the first transfer after rst_n is released SHALL take effect at the first rising edge with rst_n high.

Verification
REQ-032 MODE=0, N=4, WIDTH=5: sel=2, in_valid=4'b0100, ch2=5'h15, out_ready=1 -> in_ready=4'b0100; next cycle out_data=5'h15, grant=2, out_valid=1.
REQ-033 MODE=0, out_ready=0 with out_valid=1 -> in_ready=0 for 5 cycles with out_data stable; out_ready=1 with ch1 valid and sel=1 -> drain and reload in the same cycle, no bubble.
REQ-034 MODE=1, all in_valid=1 held, out_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 MODE=1, ptr=3, in_valid=4'b0011 -> winner=0 (wrap); next winner=1.
REQ-036 flush=1 while out_valid=1 and ch0 valid -> no capture, in_ready=0, out_valid=0 next cycle, ptr unchanged.
REQ-037 rst_n driven low between clk edges with out_valid=1 -> out_valid=0, out_data=0, grant=0 immediately.

Source files
------------

// File: rtl/arb_mux.sv
// N-to-1 channel mux with sel-driven or round-robin choice feeding a registered output stage.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a channel is accepted only when the output slot is empty or draining, and never while flush is high.
module arb_mux #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SW   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SW-1:0]        grant
);

    logic          load_en;
    logic          accept;
    logic          sel_ok;
    logic          win_vld;
    logic [SW-1:0] win_idx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] cidx;
    logic          xfer;

    assign load_en = !out_valid || out_ready;
    // rst_n gates acceptance so nothing is offered upstream while the stage is held in reset
    assign accept  = load_en && !flush && rst_n;
    assign sel_ok  = (32'(sel) < N);

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            int            ii;
            logic [SW-1:0] idx;
            ii = int'(ptr) + k;
            if (ii >= N) ii = ii - N;
            idx = SW'(ii);
            if (!win_vld && in_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        cidx     = '0;
        if (MODE == 1) begin
            cidx = win_idx;
            if (win_vld) in_ready[win_idx] = accept;
        end else begin
            cidx = sel;
            if (sel_ok) in_ready[sel] = accept;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        if (int'(win_idx) + 1 >= N) ptr_nxt = '0;
        else                        ptr_nxt = win_idx + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(cidx)*WIDTH +: WIDTH];
                grant     <= cidx;
                if (MODE == 1) ptr <= ptr_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench: one sel-driven and one round-robin instance sharing clock and reset.
module tb_arb_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic [19:0] in_data0, in_data1;
    logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
    logic [1:0]  sel0, sel1, grant0, grant1;
    logic        flush0, flush1, out_valid0, out_valid1, out_ready0, out_ready1;
    logic [4:0]  out_data0, out_data1;
    logic [4:0]  d1 [4];

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(5), .N(4), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .sel(sel0), .flush(flush0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .grant(grant0));

    arb_mux #(.WIDTH(5), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sel(sel1), .flush(flush1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .grant(grant1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_data0 = {5'h0A, 5'h15, 5'h07, 5'h03};
        in_data1 = {5'h1D, 5'h0C, 5'h02, 5'h11};
        d1[0] = 5'h11; d1[1] = 5'h02; d1[2] = 5'h0C; d1[3] = 5'h1D;
        in_valid0 = 4'hF; in_valid1 = 4'hF;
        sel0 = 2'd0; sel1 = 2'd0;
        flush0 = 1'b0; flush1 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        tick();
        tick();
        chk("rst_out_valid0", 64'(out_valid0), 64'(1'b0));
        chk("rst_out_data0", 64'(out_data0), 64'(5'h00));
        chk("rst_grant0", 64'(grant0), 64'(2'd0));
        chk("rst_in_ready0", 64'(in_ready0), 64'(4'b0000));
        chk("rst_in_ready1", 64'(in_ready1), 64'(4'b0000));
        chk("rst_out_valid1", 64'(out_valid1), 64'(1'b0));

        // sel-driven basic transfer
        rst_n = 1'b1;
        in_valid0 = 4'b0100; sel0 = 2'd2; out_ready0 = 1'b1;
        in_valid1 = 4'b0000;
        #1;
        chk("sel2_in_ready", 64'(in_ready0), 64'(4'b0100));
        tick();
        chk("sel2_out_data", 64'(out_data0), 64'(5'h15));
        chk("sel2_grant", 64'(grant0), 64'(2'd2));
        chk("sel2_out_valid", 64'(out_valid0), 64'(1'b1));

        // stall for 5 cycles, then drain and reload in one cycle
        out_ready0 = 1'b0; in_valid0 = 4'b0010; sel0 = 2'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready0), 64'(4'b0000));
            tick();
            chk("stall_out_data", 64'(out_data0), 64'(5'h15));
            chk("stall_out_valid", 64'(out_valid0), 64'(1'b1));
            chk("stall_grant", 64'(grant0), 64'(2'd2));
        end
        out_ready0 = 1'b1;
        #1;
        chk("reload_in_ready", 64'(in_ready0), 64'(4'b0010));
        tick();
        chk("reload_out_data", 64'(out_data0), 64'(5'h07));
        chk("reload_grant", 64'(grant0), 64'(2'd1));
        chk("reload_out_valid", 64'(out_valid0), 64'(1'b1));

        // drain with no new transfer: in_ready follows sel regardless of in_valid
        in_valid0 = 4'b0000; sel0 = 2'd3;
        #1;
        chk("drain_in_ready", 64'(in_ready0), 64'(4'b1000));
        tick();
        chk("drain_out_valid", 64'(out_valid0), 64'(1'b0));
        chk("drain_out_data", 64'(out_data0), 64'(5'h07));
        chk("drain_grant", 64'(grant0), 64'(2'd1));

        // round-robin with all channels requesting
        in_valid1 = 4'hF; out_ready1 = 1'b1;
        #1;
        chk("rr_first_in_ready", 64'(in_ready1), 64'(4'b0001));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", 64'(grant1), 64'(k % 4));
            chk("rr_out_data", 64'(out_data1), 64'(d1[k % 4]));
            chk("rr_out_valid", 64'(out_valid1), 64'(1'b1));
        end

        // ptr is 1 here; take ch2 to move ptr to 3
        in_valid1 = 4'b0100;
        #1;
        chk("rr_ch2_in_ready", 64'(in_ready1), 64'(4'b0100));
        tick();
        chk("rr_ch2_grant", 64'(grant1), 64'(2'd2));
        in_valid1 = 4'b0011;
        #1;
        chk("rr_wrap_in_ready", 64'(in_ready1), 64'(4'b0001));
        tick();
        chk("rr_wrap_grant", 64'(grant1), 64'(2'd0));
        chk("rr_wrap_out_data", 64'(out_data1), 64'(5'h11));
        #1;
        chk("rr_next_in_ready", 64'(in_ready1), 64'(4'b0010));
        tick();
        chk("rr_next_grant", 64'(grant1), 64'(2'd1));
        chk("rr_next_out_data", 64'(out_data1), 64'(5'h02));

        // flush with output held and ch0 requesting; ptr must stay at 2
        in_valid1 = 4'b0001; flush1 = 1'b1; out_ready1 = 1'b0;
        #1;
        chk("flush_in_ready", 64'(in_ready1), 64'(4'b0000));
        tick();
        chk("flush_out_valid", 64'(out_valid1), 64'(1'b0));
        chk("flush_out_data", 64'(out_data1), 64'(5'h02));
        chk("flush_grant", 64'(grant1), 64'(2'd1));
        flush1 = 1'b0; in_valid1 = 4'b0011;
        #1;
        chk("flush_ptr_in_ready", 64'(in_ready1), 64'(4'b0001));
        tick();
        chk("flush_ptr_grant", 64'(grant1), 64'(2'd0));
        chk("flush_ptr_out_valid", 64'(out_valid1), 64'(1'b1));

        // asynchronous reset between edges with a held word
        in_valid1 = 4'b0000; out_ready1 = 1'b0;
        #3;
        chk("pre_areset_out_valid", 64'(out_valid1), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid1), 64'(1'b0));
        chk("areset_out_data", 64'(out_data1), 64'(5'h00));
        chk("areset_grant", 64'(grant1), 64'(2'd0));
        tick();
        rst_n = 1'b1;
        in_valid1 = 4'b0110; out_ready1 = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready1), 64'(4'b0010));
        tick();
        chk("post_reset_grant", 64'(grant1), 64'(2'd1));
        chk("post_reset_out_data", 64'(out_data1), 64'(5'h02));
        chk("post_reset_out_valid", 64'(out_valid1), 64'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
